// File: rtl/uart_frame_tx_sequencer.sv
// uart_frame_tx_sequencer
// Feeds a multi-byte frame into a single-byte UART transmitter, most
// significant byte first, using the transmitter's done tick as the per-byte
// handshake. Frames whose 16-bit header does not match HEADER are dropped
// without transmission and counted in a saturating 8-bit counter.
module uart_frame_tx_sequencer #(
    parameter int          FRAME_BYTES = 11,
    parameter logic [15:0] HEADER      = 16'hBAFD,
    parameter int          GAP_CYCLES  = 0
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic [8*FRAME_BYTES-1:0] frame_i,
    input  logic                     frame_valid_i,
    output logic                     frame_ready_o,
    output logic [7:0]               byte_o,
    output logic                     byte_start_o,
    input  logic                     byte_done_i,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     drop_o,
    output logic [7:0]               drop_cnt_o
);

    localparam int FRAME_W = 8 * FRAME_BYTES;
    // Index and gap counter are kept at least one bit wide so that degenerate
    // parameter values still elaborate.
    localparam int IDX_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Byte k of a frame; byte 0 is the most significant byte.
    function automatic logic [7:0] byte_at(input logic [FRAME_W-1:0] frame,
                                           input logic [IDX_W-1:0]   idx);
        logic [FRAME_W-1:0] shifted;
        shifted = frame >> (8 * (FRAME_BYTES - 1 - int'(idx)));
        return shifted[7:0];
    endfunction

    // True when the top 16 bits of the frame carry the expected header.
    function automatic logic header_ok(input logic [FRAME_W-1:0] frame);
        return (frame[FRAME_W-1 -: 16] == HEADER);
    endfunction

    state_e               state_q,    state_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [GAP_W-1:0]     gap_cnt_q,  gap_cnt_d;
    logic [FRAME_W-1:0]   frame_q,    frame_d;
    logic [7:0]           byte_q,     byte_d;
    logic                 start_q,    start_d;
    logic                 done_q,     done_d;
    logic                 drop_q,     drop_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    // State, datapath and registered-output flops with asynchronous reset.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            gap_cnt_q  <= {GAP_W{1'b0}};
            frame_q    <= {FRAME_W{1'b0}};
            byte_q     <= 8'h00;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_cnt_q  <= gap_cnt_d;
            frame_q    <= frame_d;
            byte_q     <= byte_d;
            start_q    <= start_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state and next-output logic; pulses default low, data holds.
    // The start pulse is registered on the transition into START so that it
    // is high exactly while the state register reads START.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_cnt_d  = gap_cnt_q;
        frame_d    = frame_q;
        byte_d     = byte_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid_i) begin
                    frame_d = frame_i;
                    if (header_ok(frame_i)) begin
                        idx_d   = IDX_ZERO;
                        byte_d  = byte_at(frame_i, IDX_ZERO);
                        start_d = 1'b1;
                        state_d = ST_START;
                    end else begin
                        drop_d = 1'b1;
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end else begin
                            drop_cnt_d = drop_cnt_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                // A done tick coinciding with the start pulse belongs to no
                // byte of ours yet, so it is not looked at here.
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (byte_done_i) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                        if (GAP_CYCLES == 0) begin
                            byte_d  = byte_at(frame_q, idx_q + IDX_ONE);
                            start_d = 1'b1;
                            state_d = ST_START;
                        end else begin
                            gap_cnt_d = GAP_ZERO;
                            state_d   = ST_GAP;
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    byte_d  = byte_at(frame_q, idx_q);
                    start_d = 1'b1;
                    state_d = ST_START;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign frame_ready_o = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign byte_o        = byte_q;
    assign byte_start_o  = start_q;
    assign frame_done_o  = done_q;
    assign drop_o        = drop_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_tx_sequencer.sv
// Directed bench for uart_frame_tx_sequencer: one instance with no gap and
// one with a three-cycle gap. Inputs are driven 1 time unit after the rising
// edge and outputs are sampled at the same point.
module tb_uart_frame_tx_sequencer;

    logic        clk;
    logic        rst;

    logic [87:0] a_frame;
    logic        a_valid, a_ready, a_start, a_done, a_busy, a_fdone, a_drop;
    logic [7:0]  a_byte, a_dcnt;

    logic [87:0] b_frame;
    logic        b_valid, b_ready, b_start, b_done, b_busy, b_fdone, b_drop;
    logic [7:0]  b_byte, b_dcnt;

    int checks = 0;
    int errors = 0;

    localparam logic [87:0] F1  = 88'hBAFD_0102_0304_0506_0708_09;
    localparam logic [87:0] F2  = 88'hBAFD_A1B2_C3D4_E5F6_0718_29;
    localparam logic [87:0] F3  = 88'hBAFD_FF00_5AA5_C33C_8001_7E;
    localparam logic [87:0] BAD = 88'h1234_0102_0304_0506_0708_09;

    uart_frame_tx_sequencer #(.FRAME_BYTES(11), .HEADER(16'hBAFD), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst_i(rst), .frame_i(a_frame), .frame_valid_i(a_valid),
        .frame_ready_o(a_ready), .byte_o(a_byte), .byte_start_o(a_start),
        .byte_done_i(a_done), .busy_o(a_busy), .frame_done_o(a_fdone),
        .drop_o(a_drop), .drop_cnt_o(a_dcnt)
    );

    uart_frame_tx_sequencer #(.FRAME_BYTES(11), .HEADER(16'hBAFD), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst_i(rst), .frame_i(b_frame), .frame_valid_i(b_valid),
        .frame_ready_o(b_ready), .byte_o(b_byte), .byte_start_o(b_start),
        .byte_done_i(b_done), .busy_o(b_busy), .frame_done_o(b_fdone),
        .drop_o(b_drop), .drop_cnt_o(b_dcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame through instance A; the transmitter model returns done
    // 20 cycles after each start. Returns early in byte abort_at's WAIT.
    task automatic tx_frame_a(input logic [87:0] f, input logic [87:0] f_next,
                              input bit keep_valid, input int abort_at);
        logic [7:0] eb;
        a_frame = f;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_frame = f_next;
        if (!keep_valid) a_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            eb = f[87-8*k -: 8];
            chk("a_start_pulse", {31'd0, a_start}, 32'd1);
            chk("a_byte_at_start", {24'd0, a_byte}, {24'd0, eb});
            chk("a_busy_start", {31'd0, a_busy}, 32'd1);
            chk("a_ready_in_frame", {31'd0, a_ready}, 32'd0);
            chk("a_fdone_in_frame", {31'd0, a_fdone}, 32'd0);
            for (int j = 1; j < 20; j++) begin
                @(posedge clk); #1;
                chk("a_start_single", {31'd0, a_start}, 32'd0);
                chk("a_byte_hold", {24'd0, a_byte}, {24'd0, eb});
                chk("a_busy_wait", {31'd0, a_busy}, 32'd1);
                chk("a_fdone_wait", {31'd0, a_fdone}, 32'd0);
                if (k == abort_at && j == 3) return;
            end
            a_done = 1'b1;
            @(posedge clk); #1;
            a_done = 1'b0;
        end
        chk("a_frame_done", {31'd0, a_fdone}, 32'd1);
        chk("a_ready_at_done", {31'd0, a_ready}, 32'd1);
        chk("a_busy_at_done", {31'd0, a_busy}, 32'd0);
        chk("a_no_start_at_done", {31'd0, a_start}, 32'd0);
    endtask

    // Sends one frame through instance B (three-cycle gap); done returns 5
    // cycles after each start. Injects a done coincident with the first
    // start pulse and a spurious done during the gap after byte 2.
    task automatic tx_frame_b(input logic [87:0] f);
        logic [7:0] eb;
        b_frame = f;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            eb = f[87-8*k -: 8];
            chk("b_start_pulse", {31'd0, b_start}, 32'd1);
            chk("b_byte_at_start", {24'd0, b_byte}, {24'd0, eb});
            chk("b_busy_start", {31'd0, b_busy}, 32'd1);
            if (k == 0) b_done = 1'b1;
            for (int j = 1; j < 5; j++) begin
                @(posedge clk); #1;
                b_done = 1'b0;
                chk("b_start_single", {31'd0, b_start}, 32'd0);
                chk("b_byte_hold", {24'd0, b_byte}, {24'd0, eb});
                chk("b_busy_wait", {31'd0, b_busy}, 32'd1);
            end
            b_done = 1'b1;
            @(posedge clk); #1;
            b_done = 1'b0;
            if (k < 10) begin
                chk("b_gap1_no_start", {31'd0, b_start}, 32'd0);
                chk("b_gap1_busy", {31'd0, b_busy}, 32'd1);
                chk("b_gap1_fdone", {31'd0, b_fdone}, 32'd0);
                if (k == 2) b_done = 1'b1;
                @(posedge clk); #1;
                b_done = 1'b0;
                chk("b_gap2_no_start", {31'd0, b_start}, 32'd0);
                chk("b_gap2_byte_hold", {24'd0, b_byte}, {24'd0, eb});
                @(posedge clk); #1;
                chk("b_gap3_no_start", {31'd0, b_start}, 32'd0);
                @(posedge clk); #1;
            end
        end
        chk("b_frame_done", {31'd0, b_fdone}, 32'd1);
        chk("b_ready_at_done", {31'd0, b_ready}, 32'd1);
        chk("b_busy_at_done", {31'd0, b_busy}, 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        a_frame = 88'd0; a_valid = 1'b0; a_done = 1'b0;
        b_frame = 88'd0; b_valid = 1'b0; b_done = 1'b0;

        // Asynchronous reset asserted between edges takes effect at once.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_a_byte", {24'd0, a_byte}, 32'h00);
        chk("rst_a_start", {31'd0, a_start}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_fdone", {31'd0, a_fdone}, 32'd0);
        chk("rst_a_drop", {31'd0, a_drop}, 32'd0);
        chk("rst_a_dcnt", {24'd0, a_dcnt}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
        chk("rst_b_start", {31'd0, b_start}, 32'd0);
        chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
        chk("rst_b_dcnt", {24'd0, b_dcnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_a_ready", {31'd0, a_ready}, 32'd1);
        chk("idle_a_start", {31'd0, a_start}, 32'd0);

        // Valid frame, 11 bytes, no gap.
        tx_frame_a(F1, 88'd0, 1'b0, 99);
        @(posedge clk); #1;
        chk("a_fdone_single", {31'd0, a_fdone}, 32'd0);
        chk("a_no_restart", {31'd0, a_start}, 32'd0);
        chk("a_ready_after", {31'd0, a_ready}, 32'd1);

        // Header mismatch: dropped once and counted.
        a_frame = BAD;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("drop_pulse", {31'd0, a_drop}, 32'd1);
        chk("drop_cnt_1", {24'd0, a_dcnt}, 32'd1);
        chk("drop_no_start", {31'd0, a_start}, 32'd0);
        chk("drop_ready", {31'd0, a_ready}, 32'd1);
        chk("drop_busy", {31'd0, a_busy}, 32'd0);
        @(posedge clk); #1;
        chk("drop_pulse_end", {31'd0, a_drop}, 32'd0);
        chk("drop_cnt_hold", {24'd0, a_dcnt}, 32'd1);
        chk("drop_no_start2", {31'd0, a_start}, 32'd0);

        // 256 more bad frames back to back: counter saturates at 255.
        a_valid = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk); #1;
            chk("sat_cnt", {24'd0, a_dcnt}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            chk("sat_drop", {31'd0, a_drop}, 32'd1);
            chk("sat_no_start", {31'd0, a_start}, 32'd0);
        end
        a_valid = 1'b0;
        @(posedge clk); #1;
        chk("sat_drop_end", {31'd0, a_drop}, 32'd0);
        chk("sat_cnt_final", {24'd0, a_dcnt}, 32'd255);

        // Mid-frame reset during byte 5's WAIT.
        tx_frame_a(F2, 88'd0, 1'b0, 5);
        chk("mid_busy_before", {31'd0, a_busy}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, a_ready}, 32'd1);
        chk("mid_rst_byte", {24'd0, a_byte}, 32'h00);
        chk("mid_rst_dcnt", {24'd0, a_dcnt}, 32'd0);
        chk("mid_rst_start", {31'd0, a_start}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_done = 1'b1;
        @(posedge clk); #1;
        a_done = 1'b0;
        chk("stray_done_busy", {31'd0, a_busy}, 32'd0);
        chk("stray_done_start", {31'd0, a_start}, 32'd0);
        chk("stray_done_fdone", {31'd0, a_fdone}, 32'd0);
        @(posedge clk); #1;
        chk("stray_done_ready", {31'd0, a_ready}, 32'd1);
        tx_frame_a(F1, 88'd0, 1'b0, 99);
        @(posedge clk); #1;

        // Back-to-back: valid held high; frame_i switches to F2 right after
        // F1 is captured and F2 must only be taken in F1's frame_done cycle.
        tx_frame_a(F1, F2, 1'b1, 99);
        tx_frame_a(F2, 88'd0, 1'b0, 99);
        @(posedge clk); #1;
        chk("b2b_fdone_end", {31'd0, a_fdone}, 32'd0);
        chk("b2b_idle", {31'd0, a_busy}, 32'd0);

        // Gap instance: three idle cycles between done and next start.
        tx_frame_b(F3);
        @(posedge clk); #1;
        chk("b_fdone_single", {31'd0, b_fdone}, 32'd0);
        chk("b_no_restart", {31'd0, b_start}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
